// File: rtl/coh_pkg.sv
// ---------------------------------------------------------------------------
// coh_pkg
//   Shared coherence definitions used by the directory invalidation engine.
//   - Directory line state encodings (ST_I / ST_S / ST_M)
//   - Request type encodings (REQ_READ / REQ_WRITE)
//   - cu_id_w(): width of a CU identifier for a given CU count
//   - fsm_e: invalidation engine transaction states
// ---------------------------------------------------------------------------
package coh_pkg;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_M = 2'd2;

  localparam logic [1:0] REQ_READ  = 2'd0;
  localparam logic [1:0] REQ_WRITE = 2'd1;

  // A single-CU system still needs a 1-bit id field.
  function automatic int cu_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    FSM_IDLE     = 2'd0,
    FSM_ISSUE    = 2'd1,
    FSM_WAIT_ACK = 2'd2,
    FSM_GRANT    = 2'd3
  } fsm_e;

endpackage

// File: rtl/dir_inval_engine_ffs_pick.sv
// ---------------------------------------------------------------------------
// ffs_pick
//   Lowest-set-bit priority encoder over an NUM_CU-wide request vector.
//   Ports:
//     req    in   NUM_CU   request vector
//     idx    out  CU id    index of the lowest set bit (0 when none set)
//     found  out  1        at least one bit of req is set
// ---------------------------------------------------------------------------
module ffs_pick
  import coh_pkg::*;
#(
  parameter int NUM_CU = 16
) (
  input  logic [NUM_CU-1:0]          req,
  output logic [cu_id_w(NUM_CU)-1:0] idx,
  output logic                       found
);

  localparam int CU_W = cu_id_w(NUM_CU);

  // Scanning from the top down lets the lowest set bit win the last write.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_CU - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = CU_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dir_inval_engine.sv
// ---------------------------------------------------------------------------
// dir_inval_engine
//   Invalidation/recall engine behind the coherence directory. Accepts one
//   directory lookup result, sends an invalidation to every affected L1 other
//   than the requester (lowest CU first), collects the acks and only then
//   grants the requester. One transaction in flight at a time, which makes
//   this block the ordering point for writes to a line.
//
//   Optional feature macro: INV_ACK_TIMEOUT_EN
//     defined   : ack wait is bounded by TIMEOUT_CYC cycles; on expiry the
//                 sticky timeout_err flag is set and the grant is issued.
//     undefined : waits for acks indefinitely, timeout_err tied to 0.
//
//   Ports:
//     clk, reset                clock, synchronous active-high reset
//     in_valid/in_ready         directory result handshake
//     in_type/in_addr/in_cu     request type, line address, requester id
//     in_state/in_sharers       directory line state, sharer/owner vector
//     inv_valid/inv_ready       invalidation handshake to the network
//     inv_cu/inv_addr           invalidation target and line
//     ack_valid/ack_cu          invalidation ack from an L1
//     grant_valid/grant_ready   grant handshake to the requester
//     grant_cu/addr/type        latched request fields
//     timeout_err               sticky ack-timeout flag
// ---------------------------------------------------------------------------
module dir_inval_engine
  import coh_pkg::*;
#(
  parameter int NUM_CU      = 16,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_type,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [cu_id_w(NUM_CU)-1:0] in_cu,
  input  logic [1:0]                 in_state,
  input  logic [NUM_CU-1:0]          in_sharers,

  output logic                       inv_valid,
  input  logic                       inv_ready,
  output logic [cu_id_w(NUM_CU)-1:0] inv_cu,
  output logic [ADDR_W-1:0]          inv_addr,

  input  logic                       ack_valid,
  input  logic [cu_id_w(NUM_CU)-1:0] ack_cu,

  output logic                       grant_valid,
  input  logic                       grant_ready,
  output logic [cu_id_w(NUM_CU)-1:0] grant_cu,
  output logic [ADDR_W-1:0]          grant_addr,
  output logic [1:0]                 grant_type,

  output logic                       timeout_err
);

  localparam int                CU_W = cu_id_w(NUM_CU);
  localparam logic [NUM_CU-1:0] ONE  = NUM_CU'(1);

  fsm_e              state;
  logic [NUM_CU-1:0] pend;     // invalidations still to be sent
  logic [NUM_CU-1:0] outst;    // invalidations sent, ack not yet seen
  logic [CU_W-1:0]   req_cu_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [1:0]        req_type_q;

  logic [NUM_CU-1:0] tgt;
  logic [NUM_CU-1:0] issue_bit;
  logic [NUM_CU-1:0] ack_bit;
  logic [NUM_CU-1:0] pend_nxt;
  logic [NUM_CU-1:0] outst_nxt;
  logic [CU_W-1:0]   pick_idx;
  logic              pick_found;
  logic              inv_fire;
  logic              ack_ok;
  logic              timeout_hit;

  ffs_pick #(
    .NUM_CU (NUM_CU)
  ) u_pick (
    .req   (pend),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // The pending mask only changes on an issue handshake, so the target stays
  // put while the network back-pressures.
  assign inv_cu     = pick_idx;
  assign inv_addr   = req_addr_q;
  assign grant_cu   = req_cu_q;
  assign grant_addr = req_addr_q;
  assign grant_type = req_type_q;
  assign inv_fire   = inv_valid && inv_ready && pick_found;

  always_comb begin
    tgt = '0;
    // Writes must kill every other copy; reads only need to recall a dirty owner.
    if (((in_type == REQ_WRITE) && ((in_state == ST_S) || (in_state == ST_M))) ||
        ((in_type == REQ_READ) && (in_state == ST_M))) begin
      tgt = in_sharers & ~(ONE << in_cu);
    end

    issue_bit = inv_fire ? (ONE << pick_idx) : '0;

    // outst is checked before this cycle's issue is folded in, so an ack
    // racing its own invalidation handshake is dropped.
    ack_ok  = ack_valid && ((state == FSM_ISSUE) || (state == FSM_WAIT_ACK)) &&
              outst[ack_cu];
    ack_bit = ack_ok ? (ONE << ack_cu) : '0;

    pend_nxt  = pend & ~issue_bit;
    outst_nxt = (outst | issue_bit) & ~ack_bit;
  end

`ifdef INV_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  // Fires on the TIMEOUT_CYC-th consecutive ack-less cycle in WAIT_ACK.
  assign timeout_hit = (state == FSM_WAIT_ACK) && !ack_ok &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state != FSM_WAIT_ACK) || ack_ok) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FSM_IDLE;
      in_ready    <= 1'b1;
      inv_valid   <= 1'b0;
      grant_valid <= 1'b0;
      pend        <= '0;
      outst       <= '0;
      req_cu_q    <= '0;
      req_addr_q  <= '0;
      req_type_q  <= '0;
    end else begin
      case (state)
        FSM_IDLE: begin
          if (in_valid) begin
            req_cu_q   <= in_cu;
            req_addr_q <= in_addr;
            req_type_q <= in_type;
            in_ready   <= 1'b0;
            if (tgt == '0) begin
              state       <= FSM_GRANT;
              grant_valid <= 1'b1;
            end else begin
              pend      <= tgt;
              state     <= FSM_ISSUE;
              inv_valid <= 1'b1;
            end
          end
        end

        FSM_ISSUE: begin
          pend  <= pend_nxt;
          outst <= outst_nxt;
          if (inv_fire && (pend_nxt == '0)) begin
            inv_valid <= 1'b0;
            state     <= FSM_WAIT_ACK;
          end
        end

        FSM_WAIT_ACK: begin
          if (timeout_hit) begin
            outst       <= '0;
            state       <= FSM_GRANT;
            grant_valid <= 1'b1;
          end else begin
            outst <= outst_nxt;
            if (outst_nxt == '0) begin
              state       <= FSM_GRANT;
              grant_valid <= 1'b1;
            end
          end
        end

        FSM_GRANT: begin
          if (grant_ready) begin
            grant_valid <= 1'b0;
            in_ready    <= 1'b1;
            state       <= FSM_IDLE;
          end
        end

        default: begin
          state <= FSM_IDLE;
        end
      endcase
    end
  end

endmodule
